// File: rtl/pcpi_arb_pkg.sv
// pcpi_arb_pkg: FSM state type, RV32M decode constants and counter sizing
// shared by the PCPI multiplier arbiter and its decoder.
package pcpi_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/pcpi_mul_decode.sv
// pcpi_mul_decode: flags a valid RV32M MUL/MULH/MULHSU/MULHU instruction.
module pcpi_mul_decode
  import pcpi_arb_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] insn,
  output logic        is_mul
);
  logic unused_bits;
  assign unused_bits = ^{insn[24:15], insn[13:7]};
  assign is_mul = valid && insn[6:0] == OPCODE_OP && insn[31:25] == FUNCT7_MULDIV && !insn[14];
endmodule

// File: rtl/pcpi_mul_arbiter.sv
// pcpi_mul_arbiter: round-robin sharing of one PCPI multiplier between two
// requesters, with a watchdog that force-completes a stalled operation.
module pcpi_mul_arbiter
  import pcpi_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_valid,
  input  logic [31:0] r0_insn,
  input  logic [31:0] r0_rs1,
  input  logic [31:0] r0_rs2,
  output logic        r0_wr,
  output logic [31:0] r0_rd,
  output logic        r0_wait,
  output logic        r0_ready,
  input  logic        r1_valid,
  input  logic [31:0] r1_insn,
  input  logic [31:0] r1_rs1,
  input  logic [31:0] r1_rs2,
  output logic        r1_wr,
  output logic [31:0] r1_rd,
  output logic        r1_wait,
  output logic        r1_ready,
  output logic        m_valid,
  output logic [31:0] m_insn,
  output logic [31:0] m_rs1,
  output logic [31:0] m_rs2,
  input  logic        m_wr,
  input  logic [31:0] m_rd,
  input  logic        m_wait,
  input  logic        m_ready,
  output logic        timeout_err
);
  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  state_t state_q, state_d;
  logic gnt_q, gnt_d, last_q, last_d, m_valid_q, m_valid_d, terr_q, terr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0] m_insn_q, m_insn_d, m_rs1_q, m_rs1_d, m_rs2_q, m_rs2_d;
  logic [1:0] is_mul, ready_q, ready_d, wr_q, wr_d;
  logic [1:0][31:0] rd_q, rd_d;
  logic pick, expired, unused_m_wait;
  pcpi_mul_decode u_dec0 (.valid(r0_valid), .insn(r0_insn), .is_mul(is_mul[0]));
  pcpi_mul_decode u_dec1 (.valid(r1_valid), .insn(r1_insn), .is_mul(is_mul[1]));
  assign unused_m_wait = m_wait;
  // r1 wins only when alone or when r0 was served last
  assign pick = is_mul[1] & (~is_mul[0] | ~last_q);
  assign expired = cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    cnt_d = cnt_q;
    m_valid_d = m_valid_q;
    m_insn_d = m_insn_q;
    m_rs1_d = m_rs1_q;
    m_rs2_d = m_rs2_q;
    ready_d = '0;
    wr_d = '0;
    rd_d = '0;
    terr_d = terr_q;
    unique case (state_q)
      IDLE: if (|is_mul) begin
        state_d = BUSY;
        gnt_d = pick;
        m_valid_d = 1'b1;
        cnt_d = '0;
        m_insn_d = pick ? r1_insn : r0_insn;
        m_rs1_d = pick ? r1_rs1 : r0_rs1;
        m_rs2_d = pick ? r1_rs2 : r0_rs2;
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (m_ready || expired) begin
          state_d = RESP;
          m_valid_d = 1'b0;
          last_d = gnt_q;
          terr_d = terr_q | ~m_ready;
          // a requester that abandoned its request gets no response
          if (is_mul[gnt_q]) begin
            ready_d[gnt_q] = 1'b1;
            wr_d[gnt_q] = m_ready & m_wr;
            rd_d[gnt_q] = m_ready ? m_rd : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q <= 1'b0;
      last_q <= 1'b1;
      cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_insn_q <= '0;
      m_rs1_q <= '0;
      m_rs2_q <= '0;
      ready_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      terr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      cnt_q <= cnt_d;
      m_valid_q <= m_valid_d;
      m_insn_q <= m_insn_d;
      m_rs1_q <= m_rs1_d;
      m_rs2_q <= m_rs2_d;
      ready_q <= ready_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      terr_q <= terr_d;
    end
  end
  assign r0_wait = is_mul[0] & ~ready_q[0];
  assign r1_wait = is_mul[1] & ~ready_q[1];
  assign r0_ready = ready_q[0];
  assign r1_ready = ready_q[1];
  assign r0_wr = wr_q[0];
  assign r1_wr = wr_q[1];
  assign r0_rd = rd_q[0];
  assign r1_rd = rd_q[1];
  assign m_valid = m_valid_q;
  assign m_insn = m_insn_q;
  assign m_rs1 = m_rs1_q;
  assign m_rs2 = m_rs2_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_pcpi_mul_arbiter.sv
// tb_pcpi_mul_arbiter: random and directed traffic from two requesters against a
// stub multiplier, checked by a transaction-level arbitration/result model.
module tb_pcpi_mul_arbiter;
  logic clk = 1'b0, reset = 1'b1;
  logic [1:0] v = '0, wr, wt, rdy;
  logic [1:0][31:0] insn = '0, rs1 = '0, rs2 = '0, rd;
  logic m_valid, m_wr, m_wait, m_ready, timeout_err;
  logic [31:0] m_insn, m_rs1, m_rs2, m_rd;
  int vectors = 0, miscompares = 0, lat = 0, lat_fix = -1, mcnt;
  bit stall = 0, use_fx = 0, mlg = 1, terr_m = 0;
  logic [1:0][31:0] fx_insn, fx_rs1, fx_rs2, got_rd;
  int order[$];
  pcpi_mul_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .r0_valid(v[0]), .r0_insn(insn[0]), .r0_rs1(rs1[0]), .r0_rs2(rs2[0]),
    .r0_wr(wr[0]), .r0_rd(rd[0]), .r0_wait(wt[0]), .r0_ready(rdy[0]),
    .r1_valid(v[1]), .r1_insn(insn[1]), .r1_rs1(rs1[1]), .r1_rs2(rs2[1]),
    .r1_wr(wr[1]), .r1_rd(rd[1]), .r1_wait(wt[1]), .r1_ready(rdy[1]),
    .m_valid(m_valid), .m_insn(m_insn), .m_rs1(m_rs1), .m_rs2(m_rs2),
    .m_wr(m_wr), .m_rd(m_rd), .m_wait(m_wait), .m_ready(m_ready),
    .timeout_err(timeout_err)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mulop(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, p;
    sa = f == 2'b11 ? {32'b0, a} : {{32{a[31]}}, a};
    sb = f[1] ? {32'b0, b} : {{32{b[31]}}, b};
    p = sa * sb;
    return f == 2'b00 ? p[31:0] : p[63:32];
  endfunction
  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] op);
    return {f7, 5'd2, 5'd1, f3, 5'd3, op};
  endfunction
  function automatic logic [31:0] rnd();
    int k;
    k = $urandom_range(0, 3);
    return k == 0 ? 32'hFFFF_FFFF : k == 1 ? 32'h8000_0000 : 32'($urandom());
  endfunction
  // stub multiplier: answers after lat+1 busy cycles, never when stalled
  always_ff @(posedge clk or posedge reset) mcnt <= reset ? 0 : (m_valid ? mcnt + 1 : 0);
  assign m_ready = m_valid && !stall && mcnt == lat;
  assign m_rd = mulop(m_insn[13:12], m_rs1, m_rs2);
  assign m_wr = 1'b1;
  assign m_wait = m_valid && !m_ready;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input int n);
    v[n] = 1'b1;
    insn[n] = use_fx ? fx_insn[n] : mk(7'b0000001, 3'($urandom_range(0, 3)), 7'b0110011);
    rs1[n] = use_fx ? fx_rs1[n] : rnd();
    rs2[n] = use_fx ? fx_rs2[n] : rnd();
  endtask
  task automatic do_reset();
    v = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ctl", {m_valid, rdy, wr, wt, timeout_err}, 0);
    chk("rst_ops", {m_insn, m_rs1}, 0);
    chk("rst_rd", {m_rs2, rd[0] | rd[1]}, 0);
    reset = 1'b0;
    mlg = 1;
    terr_m = 0;
  endtask
  // each requester issues n ops, re-requesting with probability pct after a one-cycle cooldown
  task automatic run(input int n0, input int n1, input int pct, input bit stall_i);
    int rem[2], cool[2];
    int owner, since, bc, left;
    rem[0] = n0; rem[1] = n1; cool[0] = 0; cool[1] = 0;
    owner = -1; since = 2; bc = 0; stall = stall_i;
    for (int cyc = 0; cyc < 3000 && (rem[0] + rem[1] > 0 || v != 0 || owner >= 0); cyc++) begin
      @(negedge clk);
      since++;
      if (owner < 0) begin
        chk("grant_timing", m_valid, v != 0 && since >= 2);
        if (m_valid) begin
          owner = v == 2'b11 ? (mlg ? 0 : 1) : (v[1] ? 1 : 0);
          mlg = owner[0];
          chk("m_insn", m_insn, insn[owner]);
          chk("m_ops", {m_rs1, m_rs2}, {rs1[owner], rs2[owner]});
          lat = lat_fix >= 0 ? lat_fix : $urandom_range(0, 7);
          bc = 0;
        end
      end
      if (rdy == 0 && owner >= 0) begin
        chk("m_hold", m_valid, 1);
        bc++;
      end
      for (int n = 0; n < 2; n++) begin
        if (rdy[n]) begin
          chk("rdy_owner", n, owner);
          chk("m_drop", m_valid, 0);
          chk("busy_cycles", bc, stall ? 8 : lat + 1);
          chk("rd", rd[n], stall ? 32'd0 : mulop(insn[n][13:12], rs1[n], rs2[n]));
          chk("wr", wr[n], !stall);
          chk("wait_at_ready", wt[n], 0);
          terr_m |= stall;
          chk("timeout_err", timeout_err, terr_m);
          got_rd[n] = rd[n];
          order.push_back(n);
          owner = -1; since = 0; v[n] = 1'b0; rem[n]--; cool[n] = 1;
        end else begin
          chk("idle_out", {rd[n], wr[n]}, 0);
          chk("wait", wt[n], v[n]);
        end
      end
      for (int n = 0; n < 2; n++) begin
        if (!v[n] && rem[n] > 0 && !cool[n] && $urandom_range(0, 99) < pct) issue(n);
        cool[n] = 0;
      end
    end
    left = rem[0] + rem[1] + (owner >= 0 ? 1 : 0);
    chk("run_budget", left, 0);
    stall = 0;
  endtask
  initial begin
    int first;
    do_reset();
    use_fx = 1;
    fx_insn[0] = mk(7'b0000001, 3'b000, 7'b0110011); fx_rs1[0] = 3; fx_rs2[0] = 7;
    order.delete();
    run(1, 0, 100, 0);
    chk("single_rd", got_rd[0], 21);
    chk("single_order", order.size(), 1);
    do_reset();
    fx_insn[0] = mk(7'b0000001, 3'b011, 7'b0110011); fx_rs1[0] = '1; fx_rs2[0] = '1;
    fx_insn[1] = mk(7'b0000001, 3'b000, 7'b0110011); fx_rs1[1] = -3; fx_rs2[1] = 7;
    order.delete();
    run(1, 1, 100, 0);
    chk("simul_order", {order[0][7:0], order[1][7:0]}, 16'h0001);
    chk("simul_r0", got_rd[0], 32'hFFFF_FFFE);
    chk("simul_r1", got_rd[1], 32'hFFFF_FFEB);
    use_fx = 0;
    first = mlg ? 0 : 1;
    order.delete();
    run(4, 4, 100, 0);
    chk("rr_count", order.size(), 8);
    foreach (order[i]) chk("rr_alternate", order[i], (i + first) % 2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      v[0] = 1'b1;
      insn[0] = k == 0 ? mk(7'b0000000, 3'b000, 7'b0110011) :
                k == 1 ? mk(7'b0000001, 3'b100, 7'b0110011) : mk(7'b0000001, 3'b000, 7'b0010011);
      repeat (5) begin
        @(negedge clk);
        chk("nonmul", {wt[0], rdy[0], m_valid}, 0);
      end
      v[0] = 1'b0;
    end
    run(12, 12, 40, 0);
    lat_fix = 7;
    run(1, 0, 100, 0);
    chk("boundary_terr", timeout_err, 0);
    lat_fix = -1;
    run(1, 0, 100, 1);
    chk("timeout_flag", timeout_err, 1);
    run(1, 1, 100, 0);
    chk("timeout_sticky", timeout_err, 1);
    @(negedge clk);
    v[1] = 1'b1;
    insn[1] = mk(7'b0000001, 3'b000, 7'b0110011);
    @(negedge clk);
    chk("drop_grant", m_valid, 1);
    lat = 2;
    v[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      chk("drop_silent", {rdy, wr[1], rd[1]}, 0);
    end
    chk("drop_done", m_valid, 0);
    mlg = 1;
    order.delete();
    run(1, 1, 100, 0);
    chk("drop_lastgrant", order[0], 0);
    @(negedge clk);
    stall = 1;
    v[1] = 1'b1;
    insn[1] = mk(7'b0000001, 3'b001, 7'b0110011); rs1[1] = -10; rs2[1] = -4;
    @(negedge clk);
    chk("rst_mid_grant", m_valid, 1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk("rst_mid_ctl", {m_valid, rdy, wr, timeout_err}, 0);
    chk("rst_mid_ops", {m_insn, m_rs1 | m_rs2 | rd[0] | rd[1]}, 0);
    v = '0;
    stall = 0;
    @(negedge clk);
    reset = 1'b0;
    mlg = 1;
    terr_m = 0;
    order.delete();
    run(1, 1, 100, 0);
    chk("rst_first_r0", order[0], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pcpi_mul_arbiter.md
PCPI_MUL_ARBITER -- requirements
Module: pcpi_mul_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of BUSY cycles before a forced abort (legal range 4..1023).
REQ-002 SHALL have port clk, input, 1, the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-004 SHALL have ports r0_valid and r1_valid, input, 1 each, the requester PCPI valid signals.
REQ-005 SHALL have ports r0_insn, r1_insn, r0_rs1, r1_rs1, r0_rs2, r1_rs2, input, 32 each, the requester instruction and operands.
REQ-006 SHALL have ports r0_wr and r1_wr, output, 1 each, meaning "result is valid for register writeback".
REQ-007 SHALL have ports r0_rd and r1_rd, output, 32 each, the requester results.
REQ-008 SHALL have ports r0_wait, r1_wait, r0_ready and r1_ready, output, 1 each, the requester handshake signals.
REQ-009 SHALL have ports m_valid, output, 1, and m_insn, m_rs1, m_rs2, output, 32 each, the multiplier-side request.
REQ-010 SHALL have ports m_wr, input, 1; m_rd, input, 32; m_wait, input, 1; and m_ready, input, 1, the multiplier-side response.
REQ-011 SHALL have port timeout_err, output, 1, a sticky flag that is set on any forced abort.

Function
REQ-012 SHALL decode a requester as "mul" when valid=1, insn[6:0]=0110011, insn[31:25]=0000001 and insn[14]=0; requests not decoded as mul are never granted and never see wait or ready.
REQ-013 SHALL drive rN_wait combinationally high while requester N is decoded as mul and its ready is not asserted, whether or not it is granted.
REQ-014 SHALL implement a three-state FSM with states IDLE, BUSY and RESP.
REQ-015 IDLE: SHALL grant on a decoded request, latch that requester's insn, rs1 and rs2 into m_insn, m_rs1 and m_rs2, set m_valid to 1, clear the timeout counter and move to BUSY.
REQ-016 IDLE arbitration: when only one requester is decoded, that one is granted; when both are decoded, the requester not in last_grant is granted (round-robin).
REQ-017 BUSY: SHALL hold m_valid and the operands stable and increment the timeout counter each cycle.
REQ-018 BUSY on m_ready=1: SHALL register m_rd into rN_rd and m_wr into rN_wr of the granted requester, pulse rN_ready, set m_valid to 0, update last_grant and move to RESP.
REQ-019 BUSY on counter reaching TIMEOUT_CYCLES-1 without m_ready: SHALL set rN_rd=0 and rN_wr=0, pulse rN_ready, set m_valid to 0 and timeout_err to 1, update last_grant and move to RESP.
REQ-020 If m_ready and the timeout condition occur in the same cycle, SHALL treat it as a normal completion and leave timeout_err unchanged.
REQ-021 RESP: SHALL clear ready, wr and rd and return to IDLE; new grants are made only from IDLE, so m_valid is low for at least one cycle between operations.
REQ-022 If the granted requester drops valid during BUSY, SHALL still run the operation to completion or timeout, discard the result (no ready, wr or rd driven) and still update last_grant.
REQ-023 The non-granted requester's ready, wr and rd SHALL stay 0 throughout.
REQ-024 Arbiter latency SHALL be: request sampled at edge E, m_valid high after E, rN_ready high for exactly one cycle, the cycle after m_ready is sampled.

Reset
REQ-025 On reset the block SHALL enter IDLE, clear all registered outputs (m_valid, m_insn, m_rs1, m_rs2, rN_ready, rN_wr, rN_rd, timeout_err) and the timeout counter, and set last_grant=1 so that requester 0 wins first.
REQ-026 A reset asserted mid-operation SHALL abort it immediately, produce no ready pulse and drop m_valid asynchronously.

Structure
REQ-027 Shared package pcpi_arb_pkg SHALL hold the FSM state enum, the OPCODE_OP=0110011 and FUNCT7_MULDIV=0000001 constants, and the counter width derived from TIMEOUT_CYCLES.
REQ-028 One combinational sub-module, pcpi_mul_decode (insn and valid in, is_mul out), SHALL be instantiated once per requester.

Verification
REQ-029 Single request: r0 MUL with rs1=3 and rs2=7, r1 idle -> m_valid asserted, r0_ready pulses once, r0_rd=21, r0_wr=1, r1 outputs stay 0.
REQ-030 Simultaneous requests after reset: r0 MULHU with 0xFFFFFFFF x 0xFFFFFFFF, r1 MUL with -3 x 7 -> r0 served first with rd=0xFFFFFFFE, then r1 with rd=0xFFFFFFEB, and m_valid low for at least one cycle between the two.
REQ-031 Round-robin fairness: both requesters continuously re-request 4 times each -> grants alternate 0,1,0,1,... and neither requester waits more than one foreign operation.
REQ-032 Non-mul request: r0 issues insn with funct7=0000000 -> r0_wait=0, r0_ready never asserts, m_valid stays 0.
REQ-033 Timeout: stub multiplier never asserts m_ready with TIMEOUT_CYCLES=8 -> r0_ready pulses with r0_rd=0 and r0_wr=0 after 8 BUSY cycles, timeout_err=1 and stays 1.
REQ-034 Reset mid-BUSY: reset asserted 3 cycles into an r1 MULH of -10 x -4 -> m_valid and all outputs 0 at once, no r1_ready, and the first request after reset is granted to r0.
